// File: rtl/kv_store_responder.sv
// Key-vault responder: per-entry key storage with a sequenced write tracker,
// one-cycle read responses and a flush sequencer that zeroes unlocked entries.
module kv_store_responder #(
   parameter int NUM_ENTRIES  = 8,
   parameter int ENTRY_DWORDS = 16,
   parameter int ENTRY_ADDR_W = 3,
   parameter int OFFSET_W     = 4,
   parameter int DEST_W       = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    read_en,
   input  logic [ENTRY_ADDR_W-1:0] read_entry,
   input  logic [OFFSET_W-1:0]     read_offset,
   output logic                    read_valid,
   output logic [31:0]             read_data,
   output logic                    read_error,
   output logic [DEST_W-1:0]       read_dest_valid,
   input  logic                    write_en,
   input  logic [ENTRY_ADDR_W-1:0] write_entry,
   input  logic [OFFSET_W-1:0]     write_offset,
   input  logic [31:0]             write_data,
   input  logic                    write_last,
   input  logic [DEST_W-1:0]       write_dest_valid,
   output logic                    write_error,
   input  logic [NUM_ENTRIES-1:0]  lock_set,
   input  logic                    flush_req,
   output logic                    busy,
   output logic [NUM_ENTRIES-1:0]  entry_valid
);

   typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
   typedef enum logic {F_IDLE, F_CLEAR} f_state_t;

   logic [31:0]             mem        [NUM_ENTRIES][ENTRY_DWORDS];
   logic [OFFSET_W-1:0]     last_dword [NUM_ENTRIES];
   logic [DEST_W-1:0]       dest_valid [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0]  lock;

   w_state_t                w_state, w_state_nxt;
   logic [ENTRY_ADDR_W-1:0] trk_entry, trk_entry_nxt;
   logic [OFFSET_W-1:0]     exp_offset, exp_offset_nxt;
   f_state_t                f_state, f_state_nxt;
   logic [ENTRY_ADDR_W-1:0] f_idx, f_idx_nxt;
   logic                    flush_start;
   logic                    seq_ok;
   logic                    accept;

   assign busy = (f_state == F_CLEAR);

   // exp_offset of zero while active means the entry ran past its last word
   always_comb begin
      seq_ok         = 1'b0;
      w_state_nxt    = w_state;
      trk_entry_nxt  = trk_entry;
      exp_offset_nxt = exp_offset;
      if (w_state == W_IDLE)
         seq_ok = (write_offset == '0);
      else
         seq_ok = (write_entry == trk_entry) && (write_offset == exp_offset) &&
                  (exp_offset != '0);
      accept = write_en && !busy && !lock[write_entry] && seq_ok;
      if (flush_start) begin
         w_state_nxt = W_IDLE;
      end else if (accept) begin
         if (write_offset == '0)
            trk_entry_nxt = write_entry;
         exp_offset_nxt = write_offset + 1'b1;
         w_state_nxt    = write_last ? W_IDLE : W_ACTIVE;
      end else if (write_en) begin
         w_state_nxt = W_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state     <= W_IDLE;
         trk_entry   <= '0;
         exp_offset  <= '0;
         write_error <= 1'b0;
      end else begin
         w_state     <= w_state_nxt;
         trk_entry   <= trk_entry_nxt;
         exp_offset  <= exp_offset_nxt;
         write_error <= write_en && !accept;
      end
   end

   always_comb begin
      flush_start = (f_state == F_IDLE) && flush_req;
      f_state_nxt = f_state;
      f_idx_nxt   = f_idx;
      case (f_state)
         F_IDLE: begin
            if (flush_req) begin
               f_state_nxt = F_CLEAR;
               f_idx_nxt   = '0;
            end
         end
         F_CLEAR: begin
            f_idx_nxt = f_idx + 1'b1;
            if (f_idx == ENTRY_ADDR_W'(NUM_ENTRIES - 1))
               f_state_nxt = F_IDLE;
         end
         default: f_state_nxt = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_state <= F_IDLE;
         f_idx   <= '0;
      end else begin
         f_state <= f_state_nxt;
         f_idx   <= f_idx_nxt;
      end
   end

   // Writes and flush clears never coincide: accept is gated off while busy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            for (int w = 0; w < ENTRY_DWORDS; w++)
               mem[e][w] <= '0;
            last_dword[e] <= '0;
            dest_valid[e] <= '0;
         end
         entry_valid <= '0;
         lock        <= '0;
      end else begin
         lock <= lock | lock_set;
         if (accept) begin
            mem[write_entry][write_offset] <= write_data;
            if (write_offset == '0)
               entry_valid[write_entry] <= 1'b0;
            if (write_last) begin
               entry_valid[write_entry] <= 1'b1;
               last_dword[write_entry]  <= write_offset;
               dest_valid[write_entry]  <= write_dest_valid;
            end
         end
         if (busy && !lock[f_idx]) begin
            for (int w = 0; w < ENTRY_DWORDS; w++)
               mem[f_idx][w] <= '0;
            entry_valid[f_idx] <= 1'b0;
            last_dword[f_idx]  <= '0;
            dest_valid[f_idx]  <= '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         read_valid      <= 1'b0;
         read_data       <= '0;
         read_error      <= 1'b0;
         read_dest_valid <= '0;
      end else begin
         read_valid      <= read_en;
         read_data       <= '0;
         read_error      <= 1'b0;
         read_dest_valid <= '0;
         if (read_en) begin
            if (busy || !entry_valid[read_entry] ||
                (read_offset > last_dword[read_entry])) begin
               read_error <= 1'b1;
            end else begin
               read_data       <= mem[read_entry][read_offset];
               read_dest_valid <= dest_valid[read_entry];
            end
         end
      end
   end

endmodule

// File: tb/tb_kv_store_responder.sv
// Directed bench for kv_store_responder: writes, sequencing errors, locks,
// flush, read/write collisions and reset aborts.
module tb_kv_store_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        read_en;
   logic [2:0]  read_entry;
   logic [3:0]  read_offset;
   logic        read_valid;
   logic [31:0] read_data;
   logic        read_error;
   logic [5:0]  read_dest_valid;
   logic        write_en;
   logic [2:0]  write_entry;
   logic [3:0]  write_offset;
   logic [31:0] write_data;
   logic        write_last;
   logic [5:0]  write_dest_valid;
   logic        write_error;
   logic [7:0]  lock_set;
   logic        flush_req;
   logic        busy;
   logic [7:0]  entry_valid;

   int vectors = 0;
   int miscompares = 0;

   logic        rv;
   logic        re;
   logic [31:0] rd;
   logic [5:0]  rdv;

   kv_store_responder dut (
      .clk              (clk),
      .reset            (reset),
      .read_en          (read_en),
      .read_entry       (read_entry),
      .read_offset      (read_offset),
      .read_valid       (read_valid),
      .read_data        (read_data),
      .read_error       (read_error),
      .read_dest_valid  (read_dest_valid),
      .write_en         (write_en),
      .write_entry      (write_entry),
      .write_offset     (write_offset),
      .write_data       (write_data),
      .write_last       (write_last),
      .write_dest_valid (write_dest_valid),
      .write_error      (write_error),
      .lock_set         (lock_set),
      .flush_req        (flush_req),
      .busy             (busy),
      .entry_valid      (entry_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_beat(input logic [2:0] e, input logic [3:0] o, input logic [31:0] d,
                             input logic last, input logic [5:0] dv);
      write_en = 1'b1; write_entry = e; write_offset = o; write_data = d;
      write_last = last; write_dest_valid = dv;
      tick();
      write_en = 1'b0; write_last = 1'b0;
   endtask

   // Offsets first..last_off, data base+offset, each beat expected to be accepted
   task automatic write_seq(input logic [2:0] e, input int first, input int last_off,
                            input logic [31:0] base, input logic with_last, input logic [5:0] dv);
      for (int i = first; i <= last_off; i++) begin
         write_beat(e, 4'(i), base + 32'(i), with_last && (i == last_off), dv);
         vectors++;
         if (write_error !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL write_seq e%0d o%0d: write_error=%b expected 0", e, i, write_error);
         end
      end
   endtask

   task automatic do_read(input logic [2:0] e, input logic [3:0] o);
      read_en = 1'b1; read_entry = e; read_offset = o;
      tick();
      read_en = 1'b0;
      rv = read_valid; re = read_error; rd = read_data; rdv = read_dest_valid;
   endtask

   task automatic test_reset();
      vectors++;
      if ({read_valid, read_error, read_data, read_dest_valid, write_error, busy, entry_valid} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: rv=%b re=%b rd=%h rdv=%h we=%b busy=%b ev=%h expected all 0",
                  read_valid, read_error, read_data, read_dest_valid, write_error, busy, entry_valid);
      end
   endtask

   task automatic test_write_read();
      write_seq(3'd2, 0, 11, 32'hA0, 1'b1, 6'h05);
      vectors++;
      if (entry_valid !== 8'h04) begin
         miscompares++;
         $display("[TB] FAIL wr_entry_valid: got %h expected 04", entry_valid);
      end
      do_read(3'd2, 4'd11);
      vectors++;
      if ({rv, re, rdv, rd} !== {1'b1, 1'b0, 6'h05, 32'hAB}) begin
         miscompares++;
         $display("[TB] FAIL rd_e2_o11: v=%b err=%b dv=%h data=%h expected 1 0 05 000000ab", rv, re, rdv, rd);
      end
      do_read(3'd2, 4'd12);
      vectors++;
      if ({rv, re, rdv, rd} !== {1'b1, 1'b1, 6'h00, 32'h0}) begin
         miscompares++;
         $display("[TB] FAIL rd_e2_o12: v=%b err=%b dv=%h data=%h expected 1 1 00 00000000", rv, re, rdv, rd);
      end
      tick();
      vectors++;
      if (read_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rd_valid_drop: got %b expected 0", read_valid);
      end
   endtask

   task automatic test_seq_error();
      write_seq(3'd3, 0, 0, 32'h30, 1'b0, 6'h00);
      write_beat(3'd3, 4'd2, 32'h32, 1'b0, 6'h00);
      vectors++;
      if (write_error !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL seq_skip_err: got %b expected 1", write_error);
      end
      tick();
      vectors++;
      if (write_error !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL seq_err_pulse: got %b expected 0", write_error);
      end
      do_read(3'd3, 4'd0);
      vectors++;
      if ({rv, re, rd} !== {1'b1, 1'b1, 32'h0}) begin
         miscompares++;
         $display("[TB] FAIL seq_rd_invalid: v=%b err=%b data=%h expected 1 1 0", rv, re, rd);
      end
      write_seq(3'd3, 0, 3, 32'h30, 1'b1, 6'h0A);
      do_read(3'd3, 4'd3);
      vectors++;
      if ({rv, re, rdv, rd} !== {1'b1, 1'b0, 6'h0A, 32'h33}) begin
         miscompares++;
         $display("[TB] FAIL seq_retry_rd: v=%b err=%b dv=%h data=%h expected 1 0 0a 00000033", rv, re, rdv, rd);
      end
      write_seq(3'd5, 0, 15, 32'h500, 1'b0, 6'h00);
      write_beat(3'd5, 4'd0, 32'h5FF, 1'b1, 6'h01);
      vectors++;
      if (write_error !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wrap_reject: got %b expected 1", write_error);
      end
      vectors++;
      if (entry_valid !== 8'h0C) begin
         miscompares++;
         $display("[TB] FAIL wrap_valid: got %h expected 0c", entry_valid);
      end
   endtask

   task automatic test_rw_collision_and_lock();
      read_en = 1'b1; read_entry = 3'd2; read_offset = 4'd0;
      write_beat(3'd2, 4'd0, 32'h55, 1'b1, 6'h05);
      read_en = 1'b0;
      vectors++;
      if ({read_valid, read_error, read_data} !== {1'b1, 1'b0, 32'hA0}) begin
         miscompares++;
         $display("[TB] FAIL collide_old: v=%b err=%b data=%h expected 1 0 000000a0", read_valid, read_error, read_data);
      end
      do_read(3'd2, 4'd0);
      vectors++;
      if ({rv, re, rd} !== {1'b1, 1'b0, 32'h55}) begin
         miscompares++;
         $display("[TB] FAIL collide_new: v=%b err=%b data=%h expected 1 0 00000055", rv, re, rd);
      end
      do_read(3'd2, 4'd1);
      vectors++;
      if (re !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL short_entry_err: got %b expected 1", re);
      end
      // restore entry 2; a read mid-write must error
      write_seq(3'd2, 0, 0, 32'hA0, 1'b0, 6'h00);
      do_read(3'd2, 4'd0);
      vectors++;
      if ({rv, re} !== 2'b11) begin
         miscompares++;
         $display("[TB] FAIL active_rd_err: v=%b err=%b expected 1 1", rv, re);
      end
      write_seq(3'd2, 1, 10, 32'hA0, 1'b0, 6'h00);
      lock_set = 8'h04;
      write_beat(3'd2, 4'd11, 32'hAB, 1'b1, 6'h05);
      lock_set = 8'h00;
      vectors++;
      if (write_error !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL lock_same_cycle: write_error=%b expected 0", write_error);
      end
      write_beat(3'd2, 4'd0, 32'h11, 1'b1, 6'h3F);
      vectors++;
      if (write_error !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL locked_write: write_error=%b expected 1", write_error);
      end
      do_read(3'd2, 4'd0);
      vectors++;
      if ({rv, re, rdv, rd} !== {1'b1, 1'b0, 6'h05, 32'hA0}) begin
         miscompares++;
         $display("[TB] FAIL locked_rd: v=%b err=%b dv=%h data=%h expected 1 0 05 000000a0", rv, re, rdv, rd);
      end
      do_read(3'd2, 4'd11);
      vectors++;
      if ({re, rd} !== {1'b0, 32'hAB}) begin
         miscompares++;
         $display("[TB] FAIL locked_rd_last: err=%b data=%h expected 0 000000ab", re, rd);
      end
   endtask

   task automatic test_flush();
      int busy_cycles;
      write_seq(3'd1, 0, 15, 32'h100, 1'b1, 6'h03);
      do_read(3'd1, 4'd15);
      vectors++;
      if ({rv, re, rdv, rd} !== {1'b1, 1'b0, 6'h03, 32'h10F}) begin
         miscompares++;
         $display("[TB] FAIL full_entry_rd: v=%b err=%b dv=%h data=%h expected 1 0 03 0000010f", rv, re, rdv, rd);
      end
      vectors++;
      if (entry_valid !== 8'h0E) begin
         miscompares++;
         $display("[TB] FAIL pre_flush_valid: got %h expected 0e", entry_valid);
      end
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      busy_cycles = 0;
      for (int c = 0; c < 20 && busy; c++) begin
         busy_cycles++;
         write_en = (c == 1); write_entry = 3'd6; write_offset = 4'd0;
         write_data = 32'h66; write_last = 1'b1; write_dest_valid = 6'h01;
         read_en = (c == 2); read_entry = 3'd2; read_offset = 4'd0;
         flush_req = (c == 3);
         tick();
         write_en = 1'b0; write_last = 1'b0; read_en = 1'b0; flush_req = 1'b0;
         if (c == 1) begin
            vectors++;
            if (write_error !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL busy_write_err: got %b expected 1", write_error);
            end
         end
         if (c == 2) begin
            vectors++;
            if ({read_valid, read_error, read_data} !== {1'b1, 1'b1, 32'h0}) begin
               miscompares++;
               $display("[TB] FAIL busy_read_err: v=%b err=%b data=%h expected 1 1 0", read_valid, read_error, read_data);
            end
         end
      end
      vectors++;
      if (busy_cycles !== 8) begin
         miscompares++;
         $display("[TB] FAIL busy_len: got %0d cycles expected 8", busy_cycles);
      end
      vectors++;
      if (entry_valid !== 8'h04) begin
         miscompares++;
         $display("[TB] FAIL post_flush_valid: got %h expected 04", entry_valid);
      end
      do_read(3'd1, 4'd0);
      vectors++;
      if ({rv, re, rd} !== {1'b1, 1'b1, 32'h0}) begin
         miscompares++;
         $display("[TB] FAIL flushed_rd: v=%b err=%b data=%h expected 1 1 0", rv, re, rd);
      end
      do_read(3'd2, 4'd0);
      vectors++;
      if ({re, rdv, rd} !== {1'b0, 6'h05, 32'hA0}) begin
         miscompares++;
         $display("[TB] FAIL kept_locked_rd: err=%b dv=%h data=%h expected 0 05 000000a0", re, rdv, rd);
      end
   endtask

   task automatic test_reset_abort();
      read_en = 1'b1; read_entry = 3'd2; read_offset = 4'd0;
      write_beat(3'd4, 4'd0, 32'h40, 1'b0, 6'h00);
      read_en = 1'b0;
      vectors++;
      if ({read_valid, read_data} !== {1'b1, 32'hA0}) begin
         miscompares++;
         $display("[TB] FAIL pre_abort_rd: v=%b data=%h expected 1 000000a0", read_valid, read_data);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({read_valid, read_error, read_data, read_dest_valid, write_error, busy, entry_valid} !== '0) begin
         miscompares++;
         $display("[TB] FAIL wr_abort_outputs: rv=%b re=%b rd=%h rdv=%h we=%b busy=%b ev=%h expected all 0",
                  read_valid, read_error, read_data, read_dest_valid, write_error, busy, entry_valid);
      end
      tick();
      reset = 1'b0;
      tick();
      vectors++;
      if (write_error !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wr_abort_no_err: got %b expected 0", write_error);
      end
      write_seq(3'd2, 0, 1, 32'h300, 1'b1, 6'h01);
      do_read(3'd2, 4'd1);
      vectors++;
      if ({rv, re, rdv, rd} !== {1'b1, 1'b0, 6'h01, 32'h301}) begin
         miscompares++;
         $display("[TB] FAIL lock_cleared: v=%b err=%b dv=%h data=%h expected 1 0 01 00000301", rv, re, rdv, rd);
      end
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL flush_busy: got %b expected 1", busy);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({busy, entry_valid, write_error, read_valid} !== '0) begin
         miscompares++;
         $display("[TB] FAIL flush_abort: busy=%b ev=%h we=%b rv=%b expected all 0", busy, entry_valid, write_error, read_valid);
      end
      tick();
      reset = 1'b0;
      tick();
      vectors++;
      if ({busy, write_error} !== 2'b00) begin
         miscompares++;
         $display("[TB] FAIL flush_abort_after: busy=%b we=%b expected 0 0", busy, write_error);
      end
   endtask

   initial begin
      reset = 1'b1;
      read_en = 1'b0; read_entry = '0; read_offset = '0;
      write_en = 1'b0; write_entry = '0; write_offset = '0; write_data = '0;
      write_last = 1'b0; write_dest_valid = '0;
      lock_set = '0; flush_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      test_reset();
      test_write_read();
      test_seq_error();
      test_rw_collision_and_lock();
      test_flush();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/kv_store_responder.md
Name: kv_store_responder

Overview:
- Key-vault side responder that services the read and write requests issued by crypto-block kv clients (for example the HMAC dest-tag writer and key/src readers).
- Holds NUM_ENTRIES key entries of up to ENTRY_DWORDS 32-bit words each, with per-entry valid, length, dest-permission and write-lock state.
- Returns read responses with a fixed one-cycle latency.
- Provides a multi-cycle flush sequencer that zeroes unlocked entries.

Parameters:
- NUM_ENTRIES, 8, number of key entries.
- ENTRY_DWORDS, 16, 32-bit words per entry (512 bits).
- ENTRY_ADDR_W, 3, entry index width, equal to clog2(NUM_ENTRIES).
- OFFSET_W, 4, word offset width, equal to clog2(ENTRY_DWORDS).
- DEST_W, 6, width of the dest-valid permission field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- read_en  in  1  read request strobe.
- read_entry  in  ENTRY_ADDR_W  entry to read.
- read_offset  in  OFFSET_W  word offset within the entry.
- read_valid  out  1  registered response strobe, one cycle after read_en.
- read_data  out  32  response data.
- read_error  out  1  response error, qualified by read_valid.
- read_dest_valid  out  DEST_W  dest permissions of the entry read, qualified by read_valid.
- write_en  in  1  write request strobe.
- write_entry  in  ENTRY_ADDR_W  destination entry.
- write_offset  in  OFFSET_W  word offset.
- write_data  in  32  data word.
- write_last  in  1  marks the final word of the entry.
- write_dest_valid  in  DEST_W  dest permissions; sampled on the write_last beat.
- write_error  out  1  one-cycle pulse, one cycle after a rejected write beat.
- lock_set  in  NUM_ENTRIES  sets sticky write-locks; the locks clear only on reset.
- flush_req  in  1  starts a flush.
- busy  out  1  flush in progress.
- entry_valid  out  NUM_ENTRIES  per-entry valid bits.

Behaviour:
- Reset (asynchronous, active-high):
  - All storage words, entry_valid, last_dword, dest_valid and lock bits are cleared to 0.
  - read_valid, read_data, read_error, read_dest_valid, write_error and busy are 0.
  - Both FSMs are in IDLE.
  - Reset asserted mid-write or mid-flush aborts the operation immediately; no error is reported.
- Per-entry state: data[ENTRY_DWORDS], valid, last_dword[OFFSET_W], dest_valid[DEST_W], lock.
- Write tracker FSM, states W_IDLE and W_ACTIVE; registers trk_entry and exp_offset.
  - A beat is accepted only when all of these hold: busy=0; lock[write_entry]=0; for W_IDLE, write_offset=0; for W_ACTIVE, write_entry=trk_entry and write_offset=exp_offset.
  - An accepted beat stores write_data.
  - An accepted offset-0 beat clears valid[write_entry], sets trk_entry, and sets exp_offset=1.
  - An accepted beat without write_last goes to (or stays in) W_ACTIVE with exp_offset incremented.
  - An accepted beat with write_last sets valid=1, last_dword=write_offset and dest_valid=write_dest_valid, then goes to W_IDLE.
  - A non-last beat at offset ENTRY_DWORDS-1 leaves exp_offset wrapped to 0; the next beat in W_ACTIVE is therefore rejected.
  - A rejected beat causes no storage change and pulses write_error the next cycle. If the tracker was in W_ACTIVE, it returns to W_IDLE and the tracked entry stays invalid.
  - Locked entries never change, except through reset.
- Read path (one-cycle latency):
  - read_valid is a registered copy of read_en.
  - Error condition: busy=1, or valid[entry]=0, or read_offset > last_dword[entry].
  - On error: read_error=1, read_data=0, read_dest_valid=0.
  - Otherwise: read_data=data[entry][offset] and read_dest_valid=dest_valid[entry].
  - A read and a write to the same word in the same cycle return the old data.
  - An entry under an active write is invalid, so reads of it error.
- Flush FSM, states F_IDLE and F_CLEAR; index register f_idx.
  - flush_req in F_IDLE enters F_CLEAR with f_idx=0 and busy=1 from the next cycle.
  - In F_CLEAR, each cycle clears entry f_idx (all words, valid, last_dword and dest_valid) if lock[f_idx]=0, then increments f_idx.
  - After entry NUM_ENTRIES-1 the FSM returns to F_IDLE. busy is high for exactly NUM_ENTRIES cycles.
  - flush_req while busy is ignored.
  - Flush start forces the write tracker to W_IDLE without a write_error.
  - Write beats during busy are rejected with write_error.
- Simultaneous lock_set and an accepted write to the same entry in the same cycle: the write completes, and the lock applies from the next cycle.

Test Plan:
- Write entry 2 offsets 0..11 with data 0xA0+i, write_last on offset 11, write_dest_valid=6'h05 -> entry_valid[2]=1. Read offset 11 gives 0xAB with read_dest_valid 6'h05; read offset 12 gives read_error=1 and read_data=0, one cycle after read_en.
- Write entry 3 offset 0, then offset 2 -> write_error pulses once. Read entry 3 offset 0 gives read_error=1. A fresh offset-0..3 sequence with write_last then succeeds.
- After the first test, lock_set[2]=1, then write entry 2 offset 0 -> write_error=1. Read offset 0 still returns 0xA0.
- Fill entries 1 and 2 (2 locked), then flush_req -> busy high for 8 cycles. After the flush, entry_valid=8'h04 and reads of entry 1 error.
- Issue a read of entry 2 offset 0 in the same cycle as a write of entry 2 offset 0 with data 0x55 -> read returns the old value 0xA0.
- Assert reset during W_ACTIVE and during F_CLEAR -> all outputs are 0, entry_valid=0, locks are cleared, and there is no write_error pulse.
